// File: rtl/reqack_fifo_if.sv
// Request/acknowledge FIFO bus: write port, read port and status flags.
// With REQACK_FIFO_COUNT_EN defined the bus also carries the occupancy count.
interface reqack_fifo_if #(
  parameter int unsigned WIDTH  = 8
`ifdef REQACK_FIFO_COUNT_EN
  ,
  parameter int unsigned ADDR_W = 5
`endif
);
  logic             wr_req;
  logic [WIDTH-1:0] data_in;
  logic             wr_ack;
  logic             rd_req;
  logic             rd_ack;
  logic [WIDTH-1:0] data_out;
  logic             fifo_full;
  logic             fifo_empty;
`ifdef REQACK_FIFO_COUNT_EN
  logic [ADDR_W:0]  fifo_count;

  modport master (
    output wr_req, data_in, rd_req,
    input  wr_ack, rd_ack, data_out, fifo_full, fifo_empty, fifo_count
  );

  modport slave (
    input  wr_req, data_in, rd_req,
    output wr_ack, rd_ack, data_out, fifo_full, fifo_empty, fifo_count
  );
`else
  modport master (
    output wr_req, data_in, rd_req,
    input  wr_ack, rd_ack, data_out, fifo_full, fifo_empty
  );

  modport slave (
    input  wr_req, data_in, rd_req,
    output wr_ack, rd_ack, data_out, fifo_full, fifo_empty
  );
`endif
endinterface

// File: rtl/reqack_fifo.sv
// Synchronous FIFO with a two-state req/ack handshake on each port.
// Each port accepts at most one transfer per two cycles; the ack pulse is the
// cycle after the accepting edge. Define REQACK_FIFO_COUNT_EN to expose the
// registered occupancy on bus.fifo_count.
module reqack_fifo #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input logic          clk,
  input logic          rst_n,
  reqack_fifo_if.slave bus
);

  typedef enum logic {StIdle, StAck} hs_state_e;

  localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  hs_state_e         wr_state_q, rd_state_q;
  logic [ADDR_W-1:0] wptr_q, rptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic [WIDTH-1:0]  data_out_q;
  logic              full_q, empty_q;
  logic              wr_accept, rd_accept;

  // Accept decisions look only at pre-edge flags: a same-edge read never frees
  // room for a write, and a same-edge write never feeds a read.
  always_comb begin
    wr_accept = bus.wr_req && (wr_state_q == StIdle) && !full_q;
    rd_accept = bus.rd_req && (rd_state_q == StIdle) && !empty_q;
    count_d   = count_q + {{ADDR_W{1'b0}}, wr_accept} - {{ADDR_W{1'b0}}, rd_accept};
  end

  // Storage array; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wptr_q] <= bus.data_in;
    end
  end

  // Handshake FSMs, pointers, read data, occupancy and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= StIdle;
      rd_state_q <= StIdle;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      unique case (wr_state_q)
        StIdle:  if (wr_accept) wr_state_q <= StAck;
        StAck:   wr_state_q <= StIdle;
        default: wr_state_q <= StIdle;
      endcase

      unique case (rd_state_q)
        StIdle:  if (rd_accept) rd_state_q <= StAck;
        StAck:   rd_state_q <= StIdle;
        default: rd_state_q <= StIdle;
      endcase

      if (wr_accept) begin
        wptr_q <= wptr_q + ADDR_W'(1);
      end
      if (rd_accept) begin
        rptr_q     <= rptr_q + ADDR_W'(1);
        data_out_q <= mem[rptr_q];
      end

      count_q <= count_d;
      full_q  <= (count_d == FullCount);
      empty_q <= (count_d == '0);
    end
  end

  assign bus.wr_ack     = (wr_state_q == StAck);
  assign bus.rd_ack     = (rd_state_q == StAck);
  assign bus.data_out   = data_out_q;
  assign bus.fifo_full  = full_q;
  assign bus.fifo_empty = empty_q;
`ifdef REQACK_FIFO_COUNT_EN
  assign bus.fifo_count = count_q;
`endif

endmodule

// File: tb/tb_reqack_fifo.sv
// Self-checking bench for reqack_fifo: a queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_reqack_fifo;

  localparam int unsigned Width = 8;
  localparam int unsigned Depth = 32;
  localparam int unsigned AddrW = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reqack_fifo_if #(.WIDTH(Width)) bus ();

  reqack_fifo #(
    .WIDTH (Width),
    .DEPTH (Depth),
    .ADDR_W(AddrW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  bit saw_full = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: a queue of stored words plus the last ack/read state.
  logic [7:0] mq[$];
  logic       m_wr_ack, m_rd_ack;
  logic [7:0] m_dout;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_wr_ack <= 1'b0;
      m_rd_ack <= 1'b0;
      m_dout   <= 8'h00;
    end else begin : model_step
      bit wa, ra;
      wa = bus.wr_req && !m_wr_ack && (mq.size() < Depth);
      ra = bus.rd_req && !m_rd_ack && (mq.size() > 0);
      if (ra) begin
        m_dout <= mq[0];
        mq.pop_front();
      end
      if (wa) mq.push_back(bus.data_in);
      m_wr_ack <= wa;
      m_rd_ack <= ra;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("wr_ack", bus.wr_ack, m_wr_ack);
      check("rd_ack", bus.rd_ack, m_rd_ack);
      check("data_out", bus.data_out, m_dout);
      check("fifo_full", bus.fifo_full, mq.size() == Depth);
      check("fifo_empty", bus.fifo_empty, mq.size() == 0);
`ifdef REQACK_FIFO_COUNT_EN
      check("fifo_count", bus.fifo_count, mq.size());
`endif
      if (bus.fifo_full) saw_full = 1'b1;
    end
  end

  task automatic wait_ack(input bit is_wr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (is_wr ? bus.wr_ack : bus.rd_ack) begin
        ok = 1'b1;
        break;
      end
    end
    check(is_wr ? "wr_ack_timeout" : "rd_ack_timeout", ok, 1);
  endtask

  task automatic wr_one(input logic [7:0] d);
    bit ok;
    bus.wr_req  = 1'b1;
    bus.data_in = d;
    wait_ack(1'b1, ok);
    bus.wr_req = 1'b0;
  endtask

  task automatic rd_one(input logic [7:0] exp, input string name);
    bit ok;
    bus.rd_req = 1'b1;
    wait_ack(1'b0, ok);
    bus.rd_req = 1'b0;
    if (ok) check(name, bus.data_out, exp);
  endtask

  logic [7:0] sent [32];

  initial begin
    bit ok;
    int acks;
    int last_ack;

    for (int i = 0; i < 32; i++) sent[i] = 8'((i * 37 + 5) ^ 8'h5A);

    bus.wr_req  = 1'b0;
    bus.rd_req  = 1'b0;
    bus.data_in = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("rst_wr_ack", bus.wr_ack, 0);
    check("rst_rd_ack", bus.rd_ack, 0);
    check("rst_data_out", bus.data_out, 8'h00);
    check("rst_empty", bus.fifo_empty, 1);
    check("rst_full", bus.fifo_full, 0);

    // Fill with wr_req held high; data changes after each ack.
    bus.wr_req = 1'b1;
    last_ack = -100;
    for (int i = 0; i < 32; i++) begin
      bus.data_in = sent[i];
      wait_ack(1'b1, ok);
      if (ok && i > 0) check("wr_gap_ge2", (cyc - last_ack) >= 2, 1);
      last_ack = cyc;
    end
    check("full_after_32", bus.fifo_full, 1);
    check("not_empty_when_full", bus.fifo_empty, 0);
    bus.data_in = 8'hEE;
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.wr_ack) acks++;
    end
    check("wr_stall_when_full", acks, 0);
    bus.wr_req = 1'b0;

    // Drain in order, then a read on empty must stall with data_out held.
    bus.rd_req = 1'b1;
    for (int i = 0; i < 32; i++) begin
      wait_ack(1'b0, ok);
      if (ok) check("rd_order", bus.data_out, sent[i]);
    end
    check("empty_after_32", bus.fifo_empty, 1);
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rd_ack) acks++;
    end
    check("rd_stall_when_empty", acks, 0);
    check("data_out_held", bus.data_out, sent[31]);
    bus.rd_req = 1'b0;

    // Pointer wrap: 20 in, 20 out, twice.
    @(negedge clk);
    saw_full = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 20; i++) wr_one(8'(8'h40 + p * 20 + i));
      for (int i = 0; i < 20; i++) rd_one(8'(8'h40 + p * 20 + i), "wrap_order");
    end
    check("full_never_in_wrap", saw_full, 0);

    // Occupancy 5, then simultaneous write and read.
    for (int i = 0; i < 5; i++) wr_one(8'(8'hA0 + i));
    @(negedge clk);
    bus.wr_req  = 1'b1;
    bus.rd_req  = 1'b1;
    bus.data_in = 8'hA5;
    @(negedge clk);
    check("sim_wr_ack", bus.wr_ack, 1);
    check("sim_rd_ack", bus.rd_ack, 1);
    check("sim_data", bus.data_out, 8'hA0);
    check("sim_full", bus.fifo_full, 0);
    check("sim_empty", bus.fifo_empty, 0);
`ifdef REQACK_FIFO_COUNT_EN
    check("sim_count", bus.fifo_count, 5);
`endif
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;

    // Occupancy 10 with a write ack in flight, then an asynchronous reset pulse.
    for (int i = 0; i < 5; i++) wr_one(8'(8'hB0 + i));
    check("pre_rst_ack", bus.wr_ack, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_empty", bus.fifo_empty, 1);
    check("mid_rst_full", bus.fifo_full, 0);
    check("mid_rst_wr_ack", bus.wr_ack, 0);
    check("mid_rst_data", bus.data_out, 8'h00);
    #1 rst_n = 1'b1;

    bus.rd_req = 1'b1;
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rd_ack) acks++;
    end
    check("rd_stall_after_rst", acks, 0);
    wr_one(8'hC7);
    wait_ack(1'b0, ok);
    if (ok) check("rd_after_rst", bus.data_out, 8'hC7);
    bus.rd_req = 1'b0;

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reqack_fifo.md
REQACK_FIFO -- requirements
Module: reqack_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 32, number of storage entries (power of two).
REQ-003 Parameter ADDR_W, default 5, pointer width; SHALL equal log2(DEPTH).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 wr_req  input  1  write request; held high by the initiator until wr_ack is sampled high.
REQ-007 data_in  input  WIDTH  write data; stable while wr_req is high.
REQ-008 wr_ack  output  1  one-cycle pulse: write accepted.
REQ-009 rd_req  input  1  read request; held high by the initiator until rd_ack is sampled high.
REQ-010 rd_ack  output  1  one-cycle pulse: data_out valid.
REQ-011 data_out  output  WIDTH  read data; registered, holds until the next accepted read.
REQ-012 fifo_full  output  1  high when occupancy == DEPTH.
REQ-013 fifo_empty  output  1  high when occupancy == 0.

Function
REQ-014 Per-port handshake FSM, states IDLE and ACK: IDLE->ACK on accept; ACK->IDLE unconditionally next cycle; wr_ack/rd_ack high exactly in ACK.
REQ-015 Write accept at a rising edge: wr_req=1, write FSM in IDLE, fifo_full=0 -> mem[wptr]<=data_in, wptr+1, wr_ack<=1.
REQ-016 Read accept at a rising edge: rd_req=1, read FSM in IDLE, fifo_empty=0 -> data_out<=mem[rptr], rptr+1, rd_ack<=1.
REQ-017 Latency: ack is high in the cycle after the accepting edge; max throughput one accept per port per two cycles; a request still high during ACK is not re-accepted.
REQ-018 Full: write request stalls (no wr_ack, no state change) until a read frees an entry; no overflow, no data loss.
REQ-019 Empty: read request stalls (no rd_ack, data_out unchanged) until a write lands.
REQ-020 Full/empty tested on pre-edge state: write with fifo_full=1 is not accepted even with a same-edge read; read with fifo_empty=1 is not accepted even with a same-edge write.
REQ-021 Simultaneous accepted read and write: both acks in the same cycle; occupancy unchanged.
REQ-022 Pointers wrap modulo DEPTH; full/empty derived from an ADDR_W+1-bit occupancy count or extra-MSB pointers; strict FIFO order across wrap.
REQ-023 Flags registered, updated on the same edge as the accept that changes occupancy.
REQ-024 Dropping wr_req/rd_req before ack is an initiator protocol violation; the block SHALL only ever act on the request level sampled at the edge.

Reset
REQ-025 rst_n=0 asynchronously: pointers=0, occupancy=0, both FSMs IDLE, wr_ack=0, rd_ack=0, data_out=0, fifo_empty=1, fifo_full=0.
REQ-026 Reset mid-transaction discards all contents and any in-flight ack; memory array is not cleared.
REQ-027 First accept possible at the first rising edge with rst_n=1.

Configuration
REQ-028 Macro REQACK_FIFO_COUNT_EN defined: extra output fifo_count [ADDR_W:0], registered occupancy, 0 on reset, updated with the flags.
REQ-029 Macro undefined: fifo_count port absent; all other behaviour identical.

Verification
REQ-030 rst_n=0 for 2 cycles, released -> wr_ack=0, rd_ack=0, data_out=0x00, fifo_empty=1, fifo_full=0.
REQ-031 32 random bytes, wr_req held high throughout, data changed after each ack -> 32 wr_ack pulses >=2 cycles apart, fifo_full=1 after 32nd; 33rd request -> no wr_ack for 10 cycles.
REQ-032 From full, 32 reads -> rd_ack data equals write order byte-for-byte; fifo_empty=1 after 32nd; 33rd rd_req -> no rd_ack for 10 cycles, data_out holds last value.
REQ-033 Occupancy 5, wr_req and rd_req asserted same edge -> wr_ack and rd_ack same cycle, flags unchanged, fifo_count=5 with REQACK_FIFO_COUNT_EN.
REQ-034 Write 20, read 20, write 20, read 20 -> order preserved across pointer wrap; fifo_full never asserted.
REQ-035 Occupancy 10, rst_n pulsed low between edges -> fifo_empty=1 immediately, pending ack cleared, next rd_req stalls until a write.
